axil_cmd_master: RTL and testbench
==================================

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256: AXI wait-cycle limit, range 2..65535.
REQ-002 SHALL have port aclk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port aresetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port cmd_valid  input  1  command present.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when both high.
REQ-006 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_addr  input  32  byte address.
REQ-008 SHALL have port cmd_wdata  input  32  write data.
REQ-009 SHALL have port cmd_wstrb  input  4  write byte strobes.
REQ-010 SHALL have port rsp_valid  output  1  response present.
REQ-011 SHALL have port rsp_ready  input  1  response consumed when both high.
REQ-012 SHALL have port rsp_rdata  output  32  read data, 0 for writes.
REQ-013 SHALL have port rsp_resp  output  2  AXI response code.
REQ-014 SHALL have port rsp_timeout  output  1  response produced by timeout.
REQ-015 SHALL have port axi  axi4_lite_if.m  -  AXI4-Lite master, drives the memory slave.

Function
REQ-016 SHALL implement FSM states IDLE, WR (AW/W issue), WR_B, RD_AR, RD_R, RSP; one transaction outstanding.
REQ-017 SHALL drive cmd_ready = 1 only in IDLE; handshake in IDLE -> WR if cmd_write else RD_AR, command fields registered.
REQ-018 SHALL assert awvalid and wvalid (or arvalid) the cycle after command handshake; awaddr/araddr = registered cmd_addr, awprot/arprot = 3'b000.
REQ-019 SHALL hold awvalid until awready seen and wvalid until wready seen, independently; same-cycle AW and W handshakes both complete; WR -> WR_B once both done.
REQ-020 SHALL assert bready only in WR_B; bvalid&bready -> RSP, capturing bresp, rsp_rdata = 0.
REQ-021 SHALL hold arvalid until arready; then RD_R with rready = 1; rvalid&rready -> RSP, capturing rdata and rresp.
REQ-022 SHALL assert rsp_valid (registered) in RSP, payload stable until rsp_ready; handshake -> IDLE, cmd_ready high the next cycle.
REQ-023 SHALL never change AXI address/data/strobe while corresponding valid is high.
REQ-024 SHALL achieve zero-wait-slave write latency: cmd handshake cycle N, AW/W cycle N+1, B cycle >= N+2, rsp_valid cycle >= N+3.

Reset
REQ-025 SHALL on aresetn low: state IDLE, cmd_ready 0 during reset, all AXI valid/ready 0, rsp_valid 0, rsp_rdata 0, rsp_resp 0, rsp_timeout 0, timeout counter 0.
REQ-026 SHALL abandon any in-flight transaction on reset mid-operation without producing a response; cmd_ready = 1 first cycle after release.

Configuration
REQ-027 SHALL compile a 16-bit timeout watchdog only when AXIL_TIMEOUT_EN is defined.
REQ-028 SHALL, with AXIL_TIMEOUT_EN, count cycles spent in WR, WR_B, RD_AR, RD_R (cleared on entry from IDLE); at count = TIMEOUT_CYCLES drop all AXI valid/ready, go to RSP with rsp_resp = 2'b11, rsp_timeout = 1, rsp_rdata = 0.
REQ-029 SHALL, without AXIL_TIMEOUT_EN, wait indefinitely; rsp_timeout tied 0, no counter logic.

Verification
REQ-030 SHALL cover write addr 0x004, data 0xDEADBEEF, strb 0xF, zero-wait slave -> rsp_valid at N+3, rsp_resp 00, readback of 0x004 returns 0xDEADBEEF.
REQ-031 SHALL cover write with awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, single B, one response.
REQ-032 SHALL cover strb 0x3 write of 0x12345678 over 0xFFFFFFFF -> read returns 0xFFFF5678.
REQ-033 SHALL cover rsp_ready held low 10 cycles -> rsp_valid/payload stable, cmd_ready 0 throughout.
REQ-034 SHALL cover aresetn pulsed low while in WR_B -> all outputs at reset values, no response, next command completes normally.
REQ-035 SHALL cover AXIL_TIMEOUT_EN, TIMEOUT_CYCLES = 16, arready never asserted -> arvalid drops after 16 cycles, rsp_resp 11, rsp_timeout 1.

Source files
------------

// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle: master drives address/data/valid and response readies, slave the rest.
interface axi4_lite_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport m (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport s (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master: one command in, one registered response out.
// Defining AXIL_TIMEOUT_EN adds a 16-bit watchdog that ends a stalled transfer with resp 2'b11.
module axil_cmd_master #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  axi4_lite_if.m      axi
);
  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RSP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_aw_done;
  logic        r_w_done;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic [1:0]  r_rsp_resp;
  logic        w_cmd_hs;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_b_hs;
  logic        w_ar_hs;
  logic        w_r_hs;
  logic        w_tmo_fire;

  // Gated by reset so the command port never advertises readiness while held in reset.
  assign cmd_ready   = (r_state == IDLE) & aresetn;
  assign w_cmd_hs    = cmd_valid & (r_state == IDLE);

  assign axi.awaddr  = r_addr;
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = (r_state == WR) & ~r_aw_done;
  assign axi.wdata   = r_wdata;
  assign axi.wstrb   = r_wstrb;
  assign axi.wvalid  = (r_state == WR) & ~r_w_done;
  assign axi.bready  = (r_state == WR_B);
  assign axi.araddr  = r_addr;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = (r_state == RD_AR);
  assign axi.rready  = (r_state == RD_R);

  assign w_aw_hs = axi.awvalid & axi.awready;
  assign w_w_hs  = axi.wvalid & axi.wready;
  assign w_b_hs  = axi.bvalid & axi.bready;
  assign w_ar_hs = axi.arvalid & axi.arready;
  assign w_r_hs  = axi.rvalid & axi.rready;

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;

`ifdef AXIL_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_tmo_cnt;
  logic        r_rsp_timeout;
  logic        w_busy;

  assign w_busy      = (r_state == WR) | (r_state == WR_B) | (r_state == RD_AR) | (r_state == RD_R);
  // A real B/R completion landing on the last allowed cycle beats the watchdog.
  assign w_tmo_fire  = w_busy & (r_tmo_cnt == TMO_LAST) & ~w_b_hs & ~w_r_hs;
  assign rsp_timeout = r_rsp_timeout;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tmo_cnt     <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (w_cmd_hs) r_tmo_cnt <= '0;
      else if (w_busy) r_tmo_cnt <= r_tmo_cnt + 16'd1;
      if (w_tmo_fire) r_rsp_timeout <= 1'b1;
      else if (w_b_hs | w_r_hs) r_rsp_timeout <= 1'b0;
    end
  end
`else
  assign w_tmo_fire  = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (cmd_valid) w_next = cmd_write ? WR : RD_AR;
      WR:      if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) w_next = WR_B;
      WR_B:    if (w_b_hs) w_next = RSP;
      RD_AR:   if (w_ar_hs) w_next = RD_R;
      RD_R:    if (w_r_hs) w_next = RSP;
      RSP:     if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_tmo_fire) w_next = RSP;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
    end else begin
      if (w_cmd_hs) begin
        r_addr    <= cmd_addr;
        r_wdata   <= cmd_wdata;
        r_wstrb   <= cmd_wstrb;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
      if (w_tmo_fire) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= '0;
        r_rsp_resp  <= 2'b11;
      end else if (w_b_hs) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= '0;
        r_rsp_resp  <= axi.bresp;
      end else if (w_r_hs) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= axi.rdata;
        r_rsp_resp  <= axi.rresp;
      end else if (r_rsp_valid & rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axil_cmd_master.sv
// Randomized bench for axil_cmd_master: delay-programmable memory slave plus a word-level reference memory.
`timescale 1ns/1ps
module tb_axil_cmd_master;
  localparam int TMO = 16;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;

  axi4_lite_if axi_bus ();

  axil_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .axi(axi_bus)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- memory slave ----------------
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [31:0] slv_mem [0:63];
  logic [31:0] ref_mem [0:63];
  bit          aw_got, w_got, b_pend, r_pend;
  logic [31:0] aw_a, w_d, r_dat;
  logic [3:0]  w_s;
  int          aw_c, w_c, b_c, ar_c, r_c;

  initial begin
    for (int i = 0; i < 64; i++) begin
      slv_mem[i] = 32'hA500_0000 + 32'(i);
      ref_mem[i] = 32'hA500_0000 + 32'(i);
    end
  end

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
      axi_bus.awready = 0; axi_bus.wready = 0; axi_bus.bvalid = 0; axi_bus.bresp = 0;
      axi_bus.arready = 0; axi_bus.rvalid = 0; axi_bus.rdata = 0; axi_bus.rresp = 0;
    end else begin
      if (axi_bus.awvalid && axi_bus.awready) begin aw_got = 1; aw_a = axi_bus.awaddr; aw_c = 0; end
      else if (axi_bus.awvalid) aw_c++;
      else aw_c = 0;
      if (axi_bus.wvalid && axi_bus.wready) begin w_got = 1; w_d = axi_bus.wdata; w_s = axi_bus.wstrb; w_c = 0; end
      else if (axi_bus.wvalid) w_c++;
      else w_c = 0;
      if (b_pend && axi_bus.bvalid && axi_bus.bready) b_pend = 0;
      else if (b_pend) b_c++;
      if (aw_got && w_got) begin
        for (int b = 0; b < 4; b++)
          if (w_s[b]) slv_mem[aw_a[7:2]][8*b +: 8] = w_d[8*b +: 8];
        aw_got = 0; w_got = 0; b_pend = 1; b_c = 0;
      end
      if (r_pend && axi_bus.rvalid && axi_bus.rready) r_pend = 0;
      else if (r_pend) r_c++;
      if (axi_bus.arvalid && axi_bus.arready) begin r_pend = 1; r_dat = slv_mem[axi_bus.araddr[7:2]]; r_c = 0; ar_c = 0; end
      else if (axi_bus.arvalid) ar_c++;
      else ar_c = 0;
      #1;
      axi_bus.awready = axi_bus.awvalid && !aw_got && (aw_c >= aw_dly);
      axi_bus.wready  = axi_bus.wvalid && !w_got && (w_c >= w_dly);
      axi_bus.bvalid  = b_pend && (b_c >= b_dly);
      axi_bus.bresp   = 2'b00;
      axi_bus.arready = axi_bus.arvalid && (ar_c >= ar_dly);
      axi_bus.rvalid  = r_pend && (r_c >= r_dly);
      axi_bus.rdata   = axi_bus.rvalid ? r_dat : 32'h0;
      axi_bus.rresp   = 2'b00;
    end
  end

  // ---------------- bus monitor ----------------
  int cyc = 0;
  int n_awv = 0, n_wv = 0, n_arv = 0, n_b_hs = 0, n_rsp_hs = 0;
  int proto_err = 0;
  bit p_aw, p_w, p_ar, p_rsp;
  logic [31:0] p_awaddr, p_wdata, p_araddr, p_rdata;
  logic [3:0]  p_wstrb;
  logic [2:0]  p_rspx;

  always @(posedge aclk) begin
    cyc++;
    if (!aresetn) begin
      p_aw = 0; p_w = 0; p_ar = 0; p_rsp = 0;
    end else begin
      if (p_aw && axi_bus.awvalid && axi_bus.awaddr !== p_awaddr) proto_err++;
      if (p_w && axi_bus.wvalid && {axi_bus.wdata, axi_bus.wstrb} !== {p_wdata, p_wstrb}) proto_err++;
      if (p_ar && axi_bus.arvalid && axi_bus.araddr !== p_araddr) proto_err++;
      if (p_rsp && (!rsp_valid || rsp_rdata !== p_rdata || {rsp_resp, rsp_timeout} !== p_rspx)) proto_err++;
      if (axi_bus.awvalid) n_awv++;
      if (axi_bus.wvalid) n_wv++;
      if (axi_bus.arvalid) n_arv++;
      if (axi_bus.bvalid && axi_bus.bready) n_b_hs++;
      if (rsp_valid && rsp_ready) n_rsp_hs++;
      p_aw = axi_bus.awvalid && !axi_bus.awready; p_awaddr = axi_bus.awaddr;
      p_w  = axi_bus.wvalid && !axi_bus.wready;   p_wdata = axi_bus.wdata; p_wstrb = axi_bus.wstrb;
      p_ar = axi_bus.arvalid && !axi_bus.arready; p_araddr = axi_bus.araddr;
      p_rsp = rsp_valid && !rsp_ready; p_rdata = rsp_rdata; p_rspx = {rsp_resp, rsp_timeout};
    end
  end

  // ---------------- command driver + reference check ----------------
  task automatic run_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int hold, input bit exp_tmo, output int lat, output logic [31:0] got);
    logic [31:0] e_rdata;
    logic [1:0]  e_resp;
    logic        e_tmo;
    logic [31:0] h_rdata;
    int          n, start, bad;
    e_tmo = exp_tmo; e_resp = exp_tmo ? 2'b11 : 2'b00; e_rdata = 32'h0;
    if (!exp_tmo && wr) begin
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
    end else if (!exp_tmo) e_rdata = ref_mem[a[7:2]];
    lat = -1; got = 32'hx;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 100) begin @(posedge aclk); #1; n++; end
    if (!cmd_ready) begin chk("cmd_ready_timeout", 0, 1); cmd_valid = 0; return; end
    start = cyc;
    @(posedge aclk); #1;
    cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    n = 0;
    while (!rsp_valid && n < 300) begin @(posedge aclk); #1; n++; end
    if (!rsp_valid) begin chk("rsp_valid_timeout", 0, 1); return; end
    lat = cyc - start;
    got = rsp_rdata;
    h_rdata = rsp_rdata; bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge aclk); #1;
      if (!rsp_valid || cmd_ready || rsp_rdata !== h_rdata) bad++;
    end
    if (hold > 0) chk("rsp_hold_stable", bad, 0);
    chk(wr ? "wr_rdata" : "rd_rdata", rsp_rdata, e_rdata);
    chk("rsp_resp", 32'(rsp_resp), 32'(e_resp));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(e_tmo));
    rsp_ready = 1;
    @(posedge aclk); #1;
    rsp_ready = 0;
    chk("idle_after_rsp", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  initial begin
    int lat, r0, n;
    logic [31:0] got;
    logic [31:0] a;
    #50000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, r0, n;
    logic [31:0] got;
    logic [31:0] a;
    // reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_outputs",
        {cmd_ready, axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid, axi_bus.bready, axi_bus.rready,
         rsp_valid, rsp_resp, rsp_timeout}, 0);
    chk("reset_rdata", rsp_rdata, 0);
    @(negedge aclk); aresetn = 1;
    @(posedge aclk); #1;
    chk("cmd_ready_after_reset", cmd_ready, 1);

    // zero-wait write then readback
    run_cmd(1, 32'h004, 32'hDEADBEEF, 4'hF, 0, 0, lat, got);
    chk("wr_latency", lat, 3);
    run_cmd(0, 32'h004, 0, 0, 0, 0, lat, got);
    chk("rd_latency", lat, 3);
    chk("readback_deadbeef", got, 32'hDEADBEEF);

    // awready delayed by 3, wready immediate
    n_awv = 0; n_wv = 0; n_b_hs = 0; n_rsp_hs = 0;
    aw_dly = 3;
    run_cmd(1, 32'h008, 32'hCAFE0001, 4'hF, 0, 0, lat, got);
    aw_dly = 0;
    chk("aw_delay_awvalid_cycles", n_awv, 4);
    chk("aw_delay_wvalid_cycles", n_wv, 1);
    chk("aw_delay_b_count", n_b_hs, 1);
    chk("aw_delay_rsp_count", n_rsp_hs, 1);

    // partial strobe merge
    run_cmd(1, 32'h010, 32'hFFFFFFFF, 4'hF, 0, 0, lat, got);
    run_cmd(1, 32'h010, 32'h12345678, 4'h3, 0, 0, lat, got);
    run_cmd(0, 32'h010, 0, 0, 0, 0, lat, got);
    chk("strobe_merge", got, 32'hFFFF5678);

    // response backpressure for 10 cycles
    run_cmd(0, 32'h004, 0, 0, 10, 0, lat, got);

    // reset while waiting for B
    b_dly = 30;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h020; cmd_wdata = 32'h5555AAAA; cmd_wstrb = 4'hF;
    n = 0;
    while (!cmd_ready && n < 100) begin @(posedge aclk); #1; n++; end
    @(posedge aclk); #1;
    cmd_valid = 0;
    n = 0;
    while (!axi_bus.bready && n < 100) begin @(posedge aclk); #1; n++; end
    chk("reached_wr_b", axi_bus.bready, 1);
    ref_mem[8] = 32'h5555AAAA;
    r0 = n_rsp_hs;
    @(negedge aclk); aresetn = 0;
    #1;
    chk("midop_reset_outputs",
        {cmd_ready, axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid, axi_bus.bready, axi_bus.rready,
         rsp_valid, rsp_resp, rsp_timeout}, 0);
    chk("midop_reset_rdata", rsp_rdata, 0);
    repeat (2) @(posedge aclk);
    @(negedge aclk); aresetn = 1;
    b_dly = 0;
    @(posedge aclk); #1;
    chk("cmd_ready_after_midop_reset", cmd_ready, 1);
    chk("midop_no_rsp_valid", rsp_valid, 0);
    chk("midop_no_rsp_hs", n_rsp_hs, r0);
    run_cmd(0, 32'h020, 0, 0, 0, 0, lat, got);
    run_cmd(1, 32'h024, 32'h01020304, 4'hF, 0, 0, lat, got);
    chk("post_reset_wr_latency", lat, 3);

`ifdef AXIL_TIMEOUT_EN
    n_arv = 0;
    ar_dly = 100000;
    run_cmd(0, 32'h030, 0, 0, 0, 1, lat, got);
    ar_dly = 0;
    chk("tmo_arvalid_cycles", n_arv, TMO);
    chk("tmo_latency", lat, TMO + 1);
    run_cmd(0, 32'h030, 0, 0, 0, 0, lat, got);
`endif

    // randomized traffic
    for (int k = 0; k < 60; k++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      a = 32'($urandom_range(0, 15)) << 2;
      run_cmd(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 2), 0, lat, got);
    end
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    for (int i = 0; i < 16; i++) begin
      run_cmd(0, 32'(i) << 2, 0, 0, 0, 0, lat, got);
    end

    chk("axi_payload_stability", proto_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
